// File: rtl/decode_exec_skid_reg_pkg.sv
// Shared decode/execute pipeline definitions: control-bundle bit positions,
// occupancy encoding of the skid register and default datapath widths.
package decode_exec_skid_reg_pkg;

   localparam int XLEN_DEF   = 64;
   localparam int CTRL_W_DEF = 16;
   localparam int REG_AW_DEF = 5;

   localparam int CTRL_REGWRITE     = 0;
   localparam int CTRL_MEMTOREG     = 1;
   localparam int CTRL_JAL          = 2;
   localparam int CTRL_MEMREAD      = 3;
   localparam int CTRL_MEMWRITE     = 4;
   localparam int CTRL_ISBRANCH     = 5;
   localparam int CTRL_ALUSRC       = 6;
   localparam int CTRL_ALUOP_LSB    = 7;   // ALUOP occupies [9:7]
   localparam int CTRL_ALUOP_W      = 3;
   localparam int CTRL_MEMSIZE_LSB  = 10;  // MEMSIZE occupies [11:10]
   localparam int CTRL_MEMSIZE_W    = 2;
   localparam int CTRL_LOADSIZE_LSB = 12;  // LOADSIZE occupies [13:12]
   localparam int CTRL_LOADSIZE_W   = 2;

   // State encoding is the number of held entries.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/decode_exec_skid_reg_pc_target_calc.sv
// Branch/JAL/JALR target: (jalr ? rs1 : pc) + imm, LSB cleared for JALR.
// Purely combinational, no backpressure.
module pc_target_calc #(
   parameter int XLEN = 64
) (
   input  logic            jalr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] sum;

   assign sum    = (jalr ? rs1_data : pc) + imm;
   assign target = {sum[XLEN-1:1], sum[0] & ~jalr};

endmodule

// File: rtl/decode_exec_skid_reg.sv
// Elastic decode->execute register with 2-entry skid buffer; 1-cycle latency when empty.
// in_ready depends only on registered occupancy, so execute stalls never reach decode combinationally.
module decode_exec_skid_reg
   import decode_exec_skid_reg_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_jalr,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_pc_plus4,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [REG_AW-1:0] out_rd,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_rs1_data,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic [XLEN-1:0]   out_pc_plus4,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic [XLEN-1:0]   out_pc_target,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   pc_plus4;
      logic [XLEN-1:0]   pc_target;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
   } entry_t;

   occ_e            state_q, state_d;
   entry_t          main_q, skid_q, in_entry;
   logic [XLEN-1:0] in_target;
   logic            in_fire, out_fire;
   logic            load_main, load_skid, skid_to_main;

   pc_target_calc #(.XLEN(XLEN)) u_pc_target_calc (
      .jalr     (in_jalr),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .imm      (in_imm),
      .target   (in_target)
   );

   assign in_entry = '{ctrl:      in_ctrl,
                       rd:        in_rd,
                       imm:       in_imm,
                       rs1_data:  in_rs1_data,
                       rs2_data:  in_rs2_data,
                       pc_plus4:  in_pc_plus4,
                       pc_target: in_target,
                       funct3:    in_funct3,
                       funct7:    in_funct7};

   assign in_ready  = (state_q != OCC_FULL);
   assign out_valid = (state_q != OCC_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_d = OCC_EMPTY;
      end else begin
         unique case (state_q)
            OCC_EMPTY: begin
               if (in_fire) begin
                  load_main = 1'b1;
                  state_d   = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (out_fire) begin
                  state_d = OCC_EMPTY;
               end else if (in_fire) begin
                  load_skid = 1'b1;
                  state_d   = OCC_FULL;
               end
            end
            OCC_FULL: begin
               if (out_fire) begin
                  skid_to_main = 1'b1;
                  state_d      = OCC_ONE;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCC_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload is only cleared by reset; a flush leaves stale data behind invalid state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) begin
            main_q <= in_entry;
         end else if (skid_to_main) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   assign out_ctrl      = out_valid ? main_q.ctrl : '0;
   assign out_rd        = main_q.rd;
   assign out_imm       = main_q.imm;
   assign out_rs1_data  = main_q.rs1_data;
   assign out_rs2_data  = main_q.rs2_data;
   assign out_pc_plus4  = main_q.pc_plus4;
   assign out_funct3    = main_q.funct3;
   assign out_funct7    = main_q.funct7;
   assign out_pc_target = main_q.pc_target;
   assign occupancy     = state_q;

endmodule

// File: tb/tb_decode_exec_skid_reg.sv
// Bench for decode_exec_skid_reg: queue-based reference model fed by accepted inputs,
// monitor compares the head entry and handshake signals every cycle.
module tb_decode_exec_skid_reg;

   localparam int XLEN   = 64;
   localparam int CTRL_W = 16;
   localparam int REG_AW = 5;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   rs1;
      logic [XLEN-1:0]   rs2;
      logic [XLEN-1:0]   pc4;
      logic [XLEN-1:0]   tgt;
      logic [2:0]        f3;
      logic [6:0]        f7;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic              in_jalr = 1'b0;
   logic [REG_AW-1:0] in_rd = '0;
   logic [XLEN-1:0]   in_imm = '0;
   logic [XLEN-1:0]   in_rs1_data = '0;
   logic [XLEN-1:0]   in_rs2_data = '0;
   logic [XLEN-1:0]   in_pc = '0;
   logic [XLEN-1:0]   in_pc_plus4 = '0;
   logic [2:0]        in_funct3 = '0;
   logic [6:0]        in_funct7 = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] out_ctrl;
   logic [REG_AW-1:0] out_rd;
   logic [XLEN-1:0]   out_imm;
   logic [XLEN-1:0]   out_rs1_data;
   logic [XLEN-1:0]   out_rs2_data;
   logic [XLEN-1:0]   out_pc_plus4;
   logic [2:0]        out_funct3;
   logic [6:0]        out_funct7;
   logic [XLEN-1:0]   out_pc_target;
   logic [1:0]        occupancy;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t pend;
   logic acc_in = 1'b0;
   logic acc_out = 1'b0;
   logic fl = 1'b0;

   always #5 clk = ~clk;

   decode_exec_skid_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_jalr(in_jalr),
      .in_rd(in_rd), .in_imm(in_imm), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_rd(out_rd),
      .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_pc_plus4(out_pc_plus4), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_pc_target(out_pc_target), .occupancy(occupancy)
   );

   function automatic logic [XLEN-1:0] ref_target(input logic jalr, input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm);
      logic [XLEN-1:0] t;
      t = (jalr ? rs1 : pc) + imm;
      if (jalr) t[0] = 1'b0;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: expected state is the model queue; sampled mid-cycle.
   always @(negedge clk) begin
      int n;
      n = sb.size();
      chk("occupancy", {62'd0, occupancy}, 64'(n));
      chk("in_ready", {63'd0, in_ready}, {63'd0, n < 2});
      chk("out_valid", {63'd0, out_valid}, {63'd0, n > 0});
      if (n > 0) begin
         chk("head_ctrl", 64'(out_ctrl), 64'(sb[0].ctrl));
         chk("head_rd", 64'(out_rd), 64'(sb[0].rd));
         chk("head_imm", 64'(out_imm), 64'(sb[0].imm));
         chk("head_rs1", 64'(out_rs1_data), 64'(sb[0].rs1));
         chk("head_rs2", 64'(out_rs2_data), 64'(sb[0].rs2));
         chk("head_pc4", 64'(out_pc_plus4), 64'(sb[0].pc4));
         chk("head_target", 64'(out_pc_target), 64'(sb[0].tgt));
         chk("head_funct", 64'({out_funct7, out_funct3}), 64'({sb[0].f7, sb[0].f3}));
      end else begin
         chk("bubble_ctrl_masked", 64'(out_ctrl), 64'd0);
      end
      if (!rst_n) begin
         chk("reset_rd", 64'(out_rd), 64'd0);
         chk("reset_target", 64'(out_pc_target), 64'd0);
         chk("reset_imm", 64'(out_imm), 64'd0);
      end
      acc_in  = rst_n && in_valid && (n < 2);
      acc_out = rst_n && out_ready && (n > 0);
      fl      = flush;
      pend    = '{ctrl: in_ctrl, rd: in_rd, imm: in_imm, rs1: in_rs1_data, rs2: in_rs2_data,
                  pc4: in_pc_plus4, tgt: ref_target(in_jalr, in_pc, in_rs1_data, in_imm),
                  f3: in_funct3, f7: in_funct7};
   end

   always @(posedge clk) begin
      if (!rst_n || fl) begin
         sb.delete();
      end else begin
         if (acc_out) void'(sb.pop_front());
         if (acc_in) sb.push_back(pend);
      end
   end

   always @(negedge rst_n) sb.delete();

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [REG_AW-1:0] rd, input logic jalr, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm);
      logic [63:0] r;
      in_valid    = 1'b1;
      in_rd       = rd;
      in_jalr     = jalr;
      in_pc       = pc;
      in_pc_plus4 = pc + XLEN'(4);
      in_rs1_data = rs1;
      in_imm      = imm;
      r           = {$urandom, $urandom};
      in_rs2_data = r[XLEN-1:0];
      in_ctrl     = CTRL_W'($urandom);
      in_funct3   = 3'($urandom);
      in_funct7   = 7'($urandom);
   endtask

   task automatic rand_drive(input logic [REG_AW-1:0] rd);
      logic [63:0] a, b, c;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      drive(rd, 1'($urandom), a[XLEN-1:0], b[XLEN-1:0], c[XLEN-1:0]);
   endtask

   // Hold the current offer until accepted; expiry is reported as a failure.
   task automatic wait_accept();
      int   n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = in_ready && rst_n;
         step();
         n++;
      end
      chk("accept_within_budget", {63'd0, ok}, 64'd1);
   endtask

   task automatic target_case(input logic jalr, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                              input logic [XLEN-1:0] imm, input logic [XLEN-1:0] exp);
      drive(5'd9, jalr, pc, rs1, imm);
      wait_accept();
      in_valid = 1'b0;
      @(negedge clk);
      chk("directed_target", 64'(out_pc_target), 64'(exp));
      step();
   endtask

   initial begin
      repeat (2) step();
      rst_n = 1'b1;

      // Streaming at full rate.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         rand_drive(REG_AW'(i));
         wait_accept();
      end
      in_valid = 1'b0;
      repeat (3) step();

      // Backpressure: 3 and 4 held, 5 refused until execute drains.
      out_ready = 1'b0;
      rand_drive(5'd3);
      wait_accept();
      rand_drive(5'd4);
      wait_accept();
      rand_drive(5'd5);
      step();
      @(negedge clk);
      chk("bp_full_occupancy", 64'(occupancy), 64'd2);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_head_rd", 64'(out_rd), 64'd3);
      step();
      out_ready = 1'b1;
      wait_accept();
      in_valid = 1'b0;
      repeat (4) step();

      // Directed targets.
      target_case(1'b0, XLEN'(64'h1000), XLEN'(0), ~XLEN'(7), XLEN'(64'hFF8));
      target_case(1'b1, XLEN'(64'h40), XLEN'(64'h2001), XLEN'(4), XLEN'(64'h2004));
      target_case(1'b1, XLEN'(64'h40), XLEN'(64'h2002), XLEN'(3), XLEN'(64'h2004));
      target_case(1'b0, ~XLEN'(3), XLEN'(0), XLEN'(8), XLEN'(4));

      // Randomised traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) rand_drive(REG_AW'(i));
         else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();

      // Flush while full with an offered entry.
      out_ready = 1'b0;
      rand_drive(5'd10);
      wait_accept();
      rand_drive(5'd11);
      wait_accept();
      rand_drive(5'd12);
      flush = 1'b1;
      @(negedge clk);
      chk("pre_flush_occupancy", 64'(occupancy), 64'd2);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
      out_ready = 1'b1;
      repeat (3) step();

      // Asynchronous reset between edges with one entry held.
      out_ready = 1'b0;
      rand_drive(5'd13);
      wait_accept();
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      chk("pre_reset_occupancy", 64'(occupancy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_occupancy", 64'(occupancy), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("arst_out_rd", 64'(out_rd), 64'd0);
      chk("arst_out_target", 64'(out_pc_target), 64'd0);
      chk("arst_out_rs1", 64'(out_rs1_data), 64'd0);
      repeat (2) step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 20; i < 24; i++) begin
         rand_drive(REG_AW'(i));
         wait_accept();
      end
      in_valid = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
